// File: rtl/edge_delay_pkg.sv
// Shared types and reset defaults for the edge delay scheduler.
// stamp_t matches the default MAX_DELAY; the top derives its own width from DW.
package edge_delay_pkg;

  typedef enum logic {
    MODE_TRANSPORT = 1'b0,
    MODE_INERTIAL  = 1'b1
  } mode_e;

  localparam int unsigned DEF_MAX_DELAY = 15;
  localparam int unsigned DEF_DEPTH     = 8;
  localparam int unsigned DEF_RST_DELAY = 4;
  localparam int unsigned DEF_STAMP_W   = $clog2(DEF_MAX_DELAY + 1) + 1;

  typedef logic [DEF_STAMP_W-1:0] stamp_t;

  localparam logic  RST_Y      = 1'b1;
  localparam logic  RST_INVERT = 1'b1;
  localparam mode_e RST_MODE   = MODE_TRANSPORT;

endpackage

// File: rtl/stamp_fifo.sv
// Circular queue of release timestamps for transport-mode events.
// A push into a full queue is accepted only when a pop frees a slot in the same cycle.
module stamp_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_push,
  input  logic [W-1:0]            i_din,
  input  logic                    i_pop,
  output logic [W-1:0]            o_head,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/edge_delay_sched.sv
// Single-bit delay scheduler: transport mode replays every edge after L = delay+1
// cycles, inertial mode only propagates levels that stay stable long enough.
module edge_delay_sched
  import edge_delay_pkg::*;
#(
  parameter int unsigned MAX_DELAY = DEF_MAX_DELAY,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned RST_DELAY = DEF_RST_DELAY,
  parameter int unsigned DW        = $clog2(MAX_DELAY + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_a_in,
  input  logic                    i_cfg_load,
  input  logic [DW-1:0]           i_cfg_delay,
  input  logic                    i_cfg_mode,
  input  logic                    i_cfg_invert,
  output logic                    o_cfg_ack,
  output logic                    o_y_out,
  output logic                    o_busy,
  output logic                    o_ovf,
  output logic [$clog2(DEPTH):0]  o_pend_cnt
);

  localparam int unsigned SW = DW + 1;
  localparam logic [DW-1:0] RST_D = DW'(RST_DELAY);

  logic          r_a_prev;
  logic          r_y;
  logic          r_invert;
  logic          r_ovf;
  logic          r_ack;
  mode_e         r_mode;
  logic [DW-1:0] r_delay;
  logic [SW-1:0] r_now;
  logic [SW-1:0] r_timer;
  logic          r_cfg_pend;
  logic [DW-1:0] r_pend_delay;
  mode_e         r_pend_mode;
  logic          r_pend_invert;

  logic          w_edge;
  logic          w_f;
  logic [SW-1:0] w_lat;
  logic [SW-1:0] w_stamp;
  logic [SW-1:0] w_head;
  logic          w_full;
  logic          w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_restart;
  logic          w_expire;
  logic          w_resync;
  logic          w_busy;
  logic          w_cfg_go;
  logic [DW-1:0] w_sat_delay;

  if ((2**DW - 1) > MAX_DELAY) begin : g_sat
    localparam logic [DW-1:0] MAX_D = DW'(MAX_DELAY);
    assign w_sat_delay = (i_cfg_delay > MAX_D) ? MAX_D : i_cfg_delay;
  end else begin : g_nosat
    assign w_sat_delay = i_cfg_delay;
  end

  assign w_edge    = i_a_in ^ r_a_prev;
  assign w_f       = r_a_prev ^ r_invert;
  assign w_lat     = {1'b0, r_delay} + 1'b1;
  assign w_stamp   = r_now + w_lat;
  assign w_push    = w_edge & (r_mode == MODE_TRANSPORT);
  assign w_pop     = ~w_empty & (w_head == r_now);
  assign w_drop    = w_push & w_full & ~w_pop;
  assign w_restart = w_edge & (r_mode == MODE_INERTIAL);
  assign w_expire  = (r_timer == SW'(1)) & ~w_restart;
  // Once edges have been lost the toggle chain is unreliable, so realign when idle.
  assign w_resync  = (r_mode == MODE_TRANSPORT) & w_empty & r_ovf & (r_y != w_f);
  assign w_busy    = (w_count != '0) | (r_timer != '0);
  assign w_cfg_go  = ~w_busy & (i_cfg_load | r_cfg_pend);

  stamp_fifo #(
    .DEPTH (DEPTH),
    .W     (SW)
  ) u_queue (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_din   (w_stamp),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a_prev      <= 1'b0;
      r_y           <= RST_Y;
      r_invert      <= RST_INVERT;
      r_mode        <= RST_MODE;
      r_delay       <= RST_D;
      r_now         <= '0;
      r_timer       <= '0;
      r_ovf         <= 1'b0;
      r_ack         <= 1'b0;
      r_cfg_pend    <= 1'b0;
      r_pend_delay  <= RST_D;
      r_pend_mode   <= RST_MODE;
      r_pend_invert <= RST_INVERT;
    end else begin
      r_a_prev <= i_a_in;
      r_now    <= r_now + 1'b1;
      r_ack    <= w_cfg_go;
      if (w_drop) r_ovf <= 1'b1;

      if (w_restart)            r_timer <= w_lat;
      else if (r_timer != '0)   r_timer <= r_timer - 1'b1;

      if (w_pop)                    r_y <= ~r_y;
      else if (w_expire | w_resync) r_y <= w_f;

      // New settings only take effect when nothing is in flight; later requests overwrite earlier ones.
      if (w_cfg_go) begin
        r_cfg_pend <= 1'b0;
        r_delay    <= i_cfg_load ? w_sat_delay : r_pend_delay;
        r_mode     <= i_cfg_load ? mode_e'(i_cfg_mode) : r_pend_mode;
        r_invert   <= i_cfg_load ? i_cfg_invert : r_pend_invert;
      end else if (i_cfg_load) begin
        r_cfg_pend    <= 1'b1;
        r_pend_delay  <= w_sat_delay;
        r_pend_mode   <= mode_e'(i_cfg_mode);
        r_pend_invert <= i_cfg_invert;
      end
    end
  end

  assign o_y_out    = r_y;
  assign o_cfg_ack  = r_ack;
  assign o_busy     = w_busy;
  assign o_ovf      = r_ovf;
  assign o_pend_cnt = w_count;

endmodule

// File: tb/tb_edge_delay_sched.sv
// Directed bench for edge_delay_sched: expected y_out edges and cfg_ack pulses are queued
// with their cycle numbers, and a negedge monitor matches them against the DUT.
`timescale 1ns/1ps
module tb_edge_delay_sched;

  localparam int DW = 4;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          a_in       = 1'b0;
  logic          cfg_load   = 1'b0;
  logic [DW-1:0] cfg_delay  = 4'd4;
  logic          cfg_mode   = 1'b0;
  logic          cfg_invert = 1'b1;
  logic          cfg_ack;
  logic          y_out;
  logic          busy;
  logic          ovf;
  logic [3:0]    pend_cnt;

  typedef struct {
    int   cyc;
    logic val;
  } ev_t;

  ev_t  y_q[$];
  int   ack_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic mon_en   = 1'b0;
  logic y_last   = 1'b1;

  edge_delay_sched dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_a_in       (a_in),
    .i_cfg_load   (cfg_load),
    .i_cfg_delay  (cfg_delay),
    .i_cfg_mode   (cfg_mode),
    .i_cfg_invert (cfg_invert),
    .o_cfg_ack    (cfg_ack),
    .o_y_out      (y_out),
    .o_busy       (busy),
    .o_ovf        (ovf),
    .o_pend_cnt   (pend_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_y(input int c, input logic v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    y_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic load_cfg(input int d, input logic m, input logic inv);
    cfg_load   = 1'b1;
    cfg_delay  = DW'(d);
    cfg_mode   = m;
    cfg_invert = inv;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  // Monitor: every y_out change and every cfg_ack pulse must match the head of its queue.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (mon_en && y_out !== y_last) begin
        n_checks++;
        if (y_q.size() == 0) begin
          $display("FAIL y_event: got y_out=%0b at cycle %0d, expected no change", y_out, cyc);
        end else begin
          e = y_q.pop_front();
          if (e.cyc == cyc && e.val === y_out) begin
            n_pass++;
            $display("y_out -> %0b at cycle %0d", y_out, cyc);
          end else begin
            $display("FAIL y_event: got y_out=%0b at cycle %0d, expected %0b at cycle %0d",
                     y_out, cyc, e.val, e.cyc);
          end
        end
      end
      y_last = y_out;
      while (y_q.size() != 0 && y_q[0].cyc < cyc) begin
        n_checks++;
        $display("FAIL y_missed: got no change, expected y_out=%0b at cycle %0d", y_q[0].val, y_q[0].cyc);
        void'(y_q.pop_front());
      end
      if (mon_en && cfg_ack === 1'b1) begin
        n_checks++;
        if (ack_q.size() != 0 && ack_q[0] == cyc) begin
          n_pass++;
          void'(ack_q.pop_front());
          $display("cfg_ack at cycle %0d", cyc);
        end else begin
          $display("FAIL cfg_ack: got pulse at cycle %0d, expected %0d", cyc,
                   (ack_q.size() != 0) ? ack_q[0] : -1);
        end
      end
      while (ack_q.size() != 0 && ack_q[0] < cyc) begin
        n_checks++;
        $display("FAIL cfg_ack_missed: got no pulse, expected at cycle %0d", ack_q[0]);
        void'(ack_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_y", y_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_pend", pend_cnt, 0);
    chk("rst_ack", cfg_ack, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Transport D=4: single rising edge
    t = cyc; a_in = 1'b1; push_y(t + 6, 1'b0);
    wait_cyc(t + 1); chk("t1_pend_first", pend_cnt, 1); chk("t1_busy", busy, 1);
    wait_cyc(t + 5); chk("t1_pend_last", pend_cnt, 1);
    wait_cyc(t + 6); chk("t1_pend_drained", pend_cnt, 0); chk("t1_idle", busy, 0);
    wait_cyc(t + 8);
    t = cyc; a_in = 1'b0; push_y(t + 6, 1'b1);
    wait_cyc(t + 8);

    // Transport: 2-cycle pulse survives
    t = cyc; a_in = 1'b1; push_y(t + 6, 1'b0);
    wait_cyc(t + 2); a_in = 1'b0; push_y(t + 8, 1'b1);
    wait_cyc(t + 12);

    // Inertial D=4: 2-cycle pulse swallowed, 6-cycle pulse passes
    t = cyc; ack_q.push_back(t + 1); load_cfg(4, 1'b1, 1'b1);
    wait_cyc(t + 3);
    t = cyc; a_in = 1'b1;
    wait_cyc(t + 2); a_in = 1'b0;
    wait_cyc(t + 4); chk("i_busy_mid", busy, 1);
    wait_cyc(t + 7); chk("i_busy_last", busy, 1);
    wait_cyc(t + 8); chk("i_busy_done", busy, 0); chk("i_swallow_y", y_out, 1);
    wait_cyc(t + 10);
    t = cyc; a_in = 1'b1; push_y(t + 6, 1'b0);
    wait_cyc(t + 6); a_in = 1'b0; push_y(t + 12, 1'b1);
    wait_cyc(t + 14);

    // Transport D=15: 11 back-to-back edges overflow an 8-deep queue
    t = cyc; ack_q.push_back(t + 1); load_cfg(15, 1'b0, 1'b1);
    wait_cyc(t + 3);
    t = cyc;
    for (int i = 0; i < 11; i++) begin
      a_in = ~a_in;
      @(negedge clk);
      if (i == 7) begin chk("ovf_before", ovf, 0); chk("pend_full", pend_cnt, 8); end
      if (i == 8) chk("ovf_set", ovf, 1);
    end
    for (int k = 0; k < 8; k++) push_y(t + 17 + k, (k % 2 == 0) ? 1'b0 : 1'b1);
    push_y(t + 25, 1'b0);
    wait_cyc(t + 26);
    chk("ovf_pend_drained", pend_cnt, 0);
    chk("ovf_resync_y", y_out, 0);
    chk("ovf_sticky", ovf, 1);

    // Config request while busy is deferred until the queue drains
    t = cyc; a_in = 1'b0; push_y(t + 17, 1'b1);
    wait_cyc(t + 2); load_cfg(0, 1'b0, 1'b0);
    ack_q.push_back(t + 18); push_y(t + 19, 1'b0);
    wait_cyc(t + 16); chk("defer_busy", busy, 1);
    wait_cyc(t + 18); chk("defer_idle", busy, 0);
    wait_cyc(t + 22);
    t = cyc; a_in = 1'b1; push_y(t + 2, 1'b1);
    wait_cyc(t + 1); chk("d0_pend", pend_cnt, 1);
    wait_cyc(t + 2); chk("d0_pend_drained", pend_cnt, 0);
    wait_cyc(t + 5);

    // Reset with three events in flight
    t = cyc; ack_q.push_back(t + 1); load_cfg(6, 1'b0, 1'b0);
    wait_cyc(t + 3);
    t = cyc; a_in = 1'b0;
    @(negedge clk); a_in = 1'b1;
    @(negedge clk); a_in = 1'b0;
    @(negedge clk);
    chk("pre_rst_pend", pend_cnt, 3);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_y", y_out, 1);
    chk("mid_rst_pend", pend_cnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ovf", ovf, 0);
    rst_n = 1'b1;
    wait_cyc(t + 20);
    chk("post_rst_y", y_out, 1);

    chk("y_queue_left", y_q.size(), 0);
    chk("ack_queue_left", ack_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/edge_delay_sched.md
Name: edge_delay_sched

Overview:
- Synthesizable, clock-based scheduler for the gate-delay datapath. It reproduces transport-style delay (every input edge is kept) and inertial-style delay (short pulses are swallowed) on a single-bit inverting or buffering path.
- Incoming edges are held as timestamped events and released after a programmable number of cycles.
- Sits between a sampled stimulus bit and the downstream logic that needs deterministic delay behaviour in silicon and FPGA.

Parameters:
- MAX_DELAY, 15, largest programmable delay in cycles.
- DEPTH, 8, transport event-queue entries; must be a power of 2.
- RST_DELAY, 4, delay loaded at reset; must be ≤ MAX_DELAY.
- DW, $clog2(MAX_DELAY+1), delay field width (derived).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- a_in  in  1  synchronous input bit, sampled every cycle.
- cfg_load  in  1  request to apply cfg_delay, cfg_mode and cfg_invert.
- cfg_delay  in  DW  requested delay D.
- cfg_mode  in  1  0 = transport, 1 = inertial.
- cfg_invert  in  1  1 = y follows ~a, 0 = y follows a.
- cfg_ack  out  1  one-cycle pulse when the configuration is applied.
- y_out  out  1  delayed output.
- busy  out  1  events pending (queue non-empty, or inertial timer running).
- ovf  out  1  sticky transport overflow flag, cleared only by reset.
- pend_cnt  out  $clog2(DEPTH)+1  number of queued transport events.

Behaviour:
- Clocking and reset: one clock (clk); synchronous active-low reset rst_n.
- Reset values:
  - y_out = 1; a_prev = 0; delay = RST_DELAY; mode = transport; invert = 1.
  - Queue empty; timer = 0; cfg_ack = 0; busy = 0; ovf = 0; pend_cnt = 0.
  - Free-running timestamp counter now = 0, width DW+1.
- Reset mid-operation: all pending events are discarded, no output toggles afterwards, and any deferred cfg_load is lost.
- Edge detection: edge = (a_in != a_prev); a_prev <= a_in every cycle. Target value f(a) = a XOR invert.
- Effective latency L = delay + 1 cycles. An edge sampled at posedge t appears on y_out at posedge t+L. Minimum latency is 1 (D=0).
- Transport mode:
  - On an edge, push stamp = now + L (mod 2^(DW+1)).
  - When the queue is non-empty and head stamp == now, pop and set y_out <= ~y_out.
  - At most one push and one pop per cycle. A simultaneous push and pop is legal and leaves pend_cnt unchanged. Stamps are strictly ordered, so equality compare is sufficient.
  - Queue full and an edge arrives with no pop that cycle: the edge is dropped and ovf <= 1.
  - Resync: when the queue is empty, ovf == 1 and y_out != f(a_prev), then y_out <= f(a_prev) next cycle.
- Inertial mode:
  - On an edge, timer <= L, restarting any running count.
  - Otherwise, while timer != 0, decrement it.
  - When timer transitions 1 -> 0, y_out <= f(a_prev). If that equals the current y_out, nothing changes: the pulse is swallowed.
  - Consequence: the input must be stable for L cycles to propagate.
- Configuration handshake:
  - cfg_load is sampled each cycle. If busy == 0 it is applied that cycle and cfg_ack pulses on the next edge.
  - If busy == 1 the request is latched (last values win) and applied on the first cycle with busy == 0, then cfg_ack pulses.
  - cfg_delay > MAX_DELAY is saturated to MAX_DELAY.
  - A changed invert does not move y_out immediately. The next event, or the next inertial expiry, uses the new f.
- busy = (pend_cnt != 0) | (timer != 0). Outputs are registered, with no combinational path from a_in to y_out.

Decomposition:
- Package edge_delay_pkg holds:
  - typedef mode_e {MODE_TRANSPORT, MODE_INERTIAL};
  - the stamp_t width;
  - the reset-default constants.
- Sub-module stamp_fifo (DEPTH x (DW+1) bits, push/pop/full/empty/count) holds the transport queue.
- Timer, edge detect and configuration handshake live in the top level.

Test Plan:
- Reset defaults, transport, D=4: a_in 0->1 at cycle 10 -> y_out 1->0 at cycle 15; pend_cnt 1 during cycles 11-15.
- Transport, D=4, 2-cycle pulse on a_in (1 at cycles 20-21) -> y_out low for exactly cycles 25-26; no pulse lost.
- Inertial, D=4, same 2-cycle pulse -> y_out stays 1. A 6-cycle pulse at cycle 40 -> y_out low from cycle 45 to 51.
- Transport, D=15, DEPTH=8, a_in toggling every cycle for 12 cycles:
  - ovf sets at the 9th edge;
  - 8 toggles appear on y_out;
  - after drain, y_out resyncs to f(a_in).
- cfg_load with D=0, invert=0 while busy:
  - no cfg_ack until the queue is empty, then one cfg_ack pulse;
  - afterwards a_in 0->1 gives y_out 0->1 one cycle later.
- rst_n asserted low with 3 events queued -> next cycle y_out=1, pend_cnt=0, busy=0, ovf=0; no later toggles.
